// File: rtl/gate_check_pkg.sv
// Shared types and truth-table constants for the gate response checker.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One stimulus slot travelling alongside the DUT pipeline.
  typedef struct packed {
    logic vld;
    logic a;
    logic b;
  } stim_t;

  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  localparam int unsigned LATENCY_MAX = 3;

  // Expected gate output for inputs {a,b}.
  function automatic logic tt_lookup(input logic [3:0] tt, input logic [1:0] ab);
    return tt[ab];
  endfunction

endpackage

// File: rtl/stim_delay_line.sv
// Shift line of {valid,a,b} that aligns captured stimulus with a pipelined DUT output.
module stim_delay_line
  import gate_check_pkg::*;
#(
  parameter int unsigned LATENCY = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic vld_i,
  input  logic a_i,
  input  logic b_i,
  output logic vld_o,
  output logic a_o,
  output logic b_o
);

  generate
    if (LATENCY == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst_n, clr_i};
      assign vld_o = vld_i;
      assign a_o   = a_i;
      assign b_o   = b_i;
    end else begin : g_line
      localparam int unsigned LAST = LATENCY - 1;
      stim_t line_q [LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < int'(LATENCY); i++) line_q[i] <= '0;
        end else if (clr_i) begin
          for (int i = 0; i < int'(LATENCY); i++) line_q[i] <= '0;
        end else begin
          line_q[0] <= '{vld: vld_i, a: a_i, b: b_i};
          for (int i = 1; i < int'(LATENCY); i++) line_q[i] <= line_q[i-1];
        end
      end

      assign vld_o = line_q[LAST].vld;
      assign a_o   = line_q[LAST].a;
      assign b_o   = line_q[LAST].b;
    end
  endgenerate

endmodule

// File: rtl/gate_response_checker.sv
// Checks a 2-input gate DUT's output against a truth table over a fixed vector budget.
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE = TT_NAND,
  parameter int unsigned NUM_VECTORS = 20,
  parameter int unsigned LATENCY     = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             dut_x,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [1:0]       first_err_ab
);

  localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VECTORS);

  state_e           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [CNT_W-1:0] vec_q, vec_d, err_q, err_d, fidx_q, fidx_d;
  logic [1:0]       fab_q, fab_d;

  logic             run_entry_c, cap_vld_c, chk_c, exp_c, mismatch_c;
  logic             dl_vld, dl_a, dl_b;
  logic [CNT_W-1:0] vec_inc_c;

  // Start is honoured only outside RUN; the entry cycle's stimulus is not captured.
  assign run_entry_c = start && (state_q != RUN);
  assign cap_vld_c   = in_valid && (state_q == RUN);

  stim_delay_line #(.LATENCY(LATENCY)) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (run_entry_c),
    .vld_i (cap_vld_c),
    .a_i   (in_a),
    .b_i   (in_b),
    .vld_o (dl_vld),
    .a_o   (dl_a),
    .b_o   (dl_b)
  );

  assign exp_c      = tt_lookup(TRUTH_TABLE, {dl_a, dl_b});
  assign mismatch_c = (dut_x !== exp_c);
  assign chk_c      = dl_vld && (state_q == RUN);
  assign vec_inc_c  = vec_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      vec_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fab_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fab_q   <= fab_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fab_d   = fab_q;

    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (chk_c && (vec_inc_c == NUM_VEC_C)) state_d = DONE;
      default:    state_d = IDLE;
    endcase

    if (run_entry_c) begin
      vec_d  = '0;
      err_d  = '0;
      fidx_d = '0;
      fab_d  = '0;
    end else if (chk_c) begin
      vec_d = vec_inc_c;
      if (mismatch_c) begin
        if (err_q != '1) err_d = err_q + CNT_W'(1);
        // First failure of the run is sticky until the next run entry.
        if (err_q == '0) begin
          fidx_d = vec_inc_c;
          fab_d  = {dl_a, dl_b};
        end
      end
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_d == '0);
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign vec_count     = vec_q;
  assign err_count     = err_q;
  assign first_err_idx = fidx_q;
  assign first_err_ab  = fab_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench: three checker configurations driven with hand-computed vectors.
module tb_gate_response_checker;
  import gate_check_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  // u0: NAND, 20 vectors, LATENCY 0
  logic       start0, vld0, a0, b0, x0, busy0, done0, pass0;
  logic [7:0] vec0, err0, fidx0;
  logic [1:0] fab0;
  // u1: NAND, 4 vectors, LATENCY 2
  logic       start1, vld1, a1, b1, x1, busy1, done1, pass1;
  logic [7:0] vec1, err1, fidx1;
  logic [1:0] fab1;
  // u2: NAND, 3 vectors, 2-bit counters
  logic       start2, vld2, a2, b2, x2, busy2, done2, pass2;
  logic [1:0] vec2, err2, fidx2, fab2;

  logic       p_v  [8];
  logic [1:0] p_ab [8];

  gate_response_checker #(.TRUTH_TABLE(TT_NAND), .NUM_VECTORS(20), .LATENCY(0), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .in_valid(vld0), .in_a(a0), .in_b(b0), .dut_x(x0),
    .busy(busy0), .done(done0), .pass(pass0), .vec_count(vec0), .err_count(err0),
    .first_err_idx(fidx0), .first_err_ab(fab0));

  gate_response_checker #(.TRUTH_TABLE(TT_NAND), .NUM_VECTORS(4), .LATENCY(2), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(vld1), .in_a(a1), .in_b(b1), .dut_x(x1),
    .busy(busy1), .done(done1), .pass(pass1), .vec_count(vec1), .err_count(err1),
    .first_err_idx(fidx1), .first_err_ab(fab1));

  gate_response_checker #(.TRUTH_TABLE(TT_NAND), .NUM_VECTORS(3), .LATENCY(0), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(vld2), .in_a(a2), .in_b(b2), .dut_x(x2),
    .busy(busy2), .done(done2), .pass(pass2), .vec_count(vec2), .err_count(err2),
    .first_err_idx(fidx2), .first_err_ab(fab2));

  task automatic drv0(input logic s, input logic v, input logic [1:0] ab, input logic x);
    start0 = s; vld0 = v; a0 = ab[1]; b0 = ab[0]; x0 = x;
    @(posedge clk); #1;
  endtask

  task automatic drv1(input logic s, input logic v, input logic [1:0] ab, input logic x);
    start1 = s; vld1 = v; a1 = ab[1]; b1 = ab[0]; x1 = x;
    @(posedge clk); #1;
  endtask

  task automatic drv2(input logic s, input logic v, input logic [1:0] ab, input logic x);
    start2 = s; vld2 = v; a2 = ab[1]; b2 = ab[0]; x2 = x;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({busy0, done0, pass0} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {busy0, done0, pass0}); end
    checks++; if ({vec0, err0, fidx0, fab0} !== 26'd0) begin fails++; $display("FAIL reset_counters: got %h want 0", {vec0, err0, fidx0, fab0}); end
    rst_n = 1'b1;
    repeat (5) drv0(1'b0, 1'b0, 2'b00, 1'b0);
    checks++; if (busy0 !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy0); end
    checks++; if (done0 !== 1'b0) begin fails++; $display("FAIL idle_done: got %b want 0", done0); end
  endtask

  task automatic test_clean_nand();
    logic [1:0] ab;
    drv0(1'b1, 1'b1, 2'b11, 1'b1);
    checks++; if (busy0 !== 1'b1 || vec0 !== 8'd0) begin fails++; $display("FAIL clean_entry: got busy=%b vec=%0d want busy=1 vec=0", busy0, vec0); end
    for (int i = 1; i <= 20; i++) begin
      ab = 2'((i - 1) % 4);
      drv0(1'b0, 1'b1, ab, ~(ab[1] & ab[0]));
      if (i == 19) begin
        checks++; if (vec0 !== 8'd19 || done0 !== 1'b0 || busy0 !== 1'b1) begin fails++; $display("FAIL clean_19: got vec=%0d done=%b busy=%b want 19 0 1", vec0, done0, busy0); end
      end
    end
    checks++; if (vec0 !== 8'd20) begin fails++; $display("FAIL clean_vec: got %0d want 20", vec0); end
    checks++; if (err0 !== 8'd0 || fidx0 !== 8'd0) begin fails++; $display("FAIL clean_err: got err=%0d fidx=%0d want 0 0", err0, fidx0); end
    checks++; if ({done0, busy0, pass0} !== 3'b101) begin fails++; $display("FAIL clean_status: got done,busy,pass=%b want 101", {done0, busy0, pass0}); end
    drv0(1'b0, 1'b1, 2'b11, 1'b1);
    drv0(1'b0, 1'b1, 2'b11, 1'b1);
    checks++; if (vec0 !== 8'd20 || err0 !== 8'd0 || done0 !== 1'b1) begin fails++; $display("FAIL done_hold: got vec=%0d err=%0d done=%b want 20 0 1", vec0, err0, done0); end
  endtask

  task automatic test_fault();
    logic [1:0] ab;
    logic       x;
    drv0(1'b1, 1'b0, 2'b00, 1'b0);
    checks++; if (vec0 !== 8'd0 || busy0 !== 1'b1 || pass0 !== 1'b0) begin fails++; $display("FAIL restart0: got vec=%0d busy=%b pass=%b want 0 1 0", vec0, busy0, pass0); end
    for (int k = 1; k <= 20; k++) begin
      ab = 2'((k - 1) % 4);
      x  = ~(ab[1] & ab[0]);
      if (k == 7 || k == 15) x = 1'b0;
      drv0(1'b0, 1'b1, ab, x);
    end
    checks++; if (err0 !== 8'd2) begin fails++; $display("FAIL fault_err: got %0d want 2", err0); end
    checks++; if (fidx0 !== 8'd7 || fab0 !== 2'b10) begin fails++; $display("FAIL fault_first: got idx=%0d ab=%b want 7 10", fidx0, fab0); end
    checks++; if ({done0, pass0} !== 2'b10 || vec0 !== 8'd20) begin fails++; $display("FAIL fault_status: got done,pass=%b vec=%0d want 10 20", {done0, pass0}, vec0); end
  endtask

  task automatic test_pipelined();
    logic x;
    p_v  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    p_ab = '{2'b00, 2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11};
    drv1(1'b1, 1'b0, 2'b00, 1'b0);
    for (int t = 0; t < 8; t++) begin
      x = (t >= 2) ? ~(p_ab[t-2][1] & p_ab[t-2][0]) : 1'b1;
      drv1(1'b0, p_v[t], p_ab[t], x);
      if (t == 6) begin
        checks++; if (done1 !== 1'b0 || vec1 !== 8'd3) begin fails++; $display("FAIL pipe_early: got done=%b vec=%0d want 0 3", done1, vec1); end
      end
      if (t == 7) begin
        checks++; if (done1 !== 1'b1) begin fails++; $display("FAIL pipe_done_edge: got %b want 1", done1); end
      end
    end
    checks++; if (vec1 !== 8'd4 || err1 !== 8'd0 || pass1 !== 1'b1) begin fails++; $display("FAIL pipe_clean: got vec=%0d err=%0d pass=%b want 4 0 1", vec1, err1, pass1); end
    drv1(1'b1, 1'b0, 2'b00, 1'b0);
    for (int t = 0; t < 8; t++) begin
      drv1(1'b0, p_v[t], p_ab[t], ~(p_ab[t][1] & p_ab[t][0]));
    end
    checks++; if (err1 !== 8'd3 || pass1 !== 1'b0 || vec1 !== 8'd4) begin fails++; $display("FAIL pipe_undelayed: got err=%0d pass=%b vec=%0d want 3 0 4", err1, pass1, vec1); end
    checks++; if (fidx1 !== 8'd2 || fab1 !== 2'b10) begin fails++; $display("FAIL pipe_first: got idx=%0d ab=%b want 2 10", fidx1, fab1); end
  endtask

  task automatic test_saturation_restart();
    drv2(1'b1, 1'b0, 2'b00, 1'b0);
    repeat (3) drv2(1'b0, 1'b1, 2'b11, 1'b1);
    checks++; if (err2 !== 2'd3 || vec2 !== 2'd3) begin fails++; $display("FAIL sat_counts: got err=%0d vec=%0d want 3 3", err2, vec2); end
    checks++; if ({done2, pass2} !== 2'b10 || fidx2 !== 2'd1 || fab2 !== 2'b11) begin fails++; $display("FAIL sat_status: got done,pass=%b idx=%0d ab=%b want 10 1 11", {done2, pass2}, fidx2, fab2); end
    drv2(1'b1, 1'b0, 2'b00, 1'b0);
    checks++; if ({vec2, err2, fidx2} !== 6'd0 || busy2 !== 1'b1 || done2 !== 1'b0) begin fails++; $display("FAIL sat_restart: got vec=%0d err=%0d idx=%0d busy=%b done=%b want 0 0 0 1 0", vec2, err2, fidx2, busy2, done2); end
    drv2(1'b0, 1'b1, 2'b00, 1'b1);
    drv2(1'b0, 1'b1, 2'b01, 1'b1);
    drv2(1'b0, 1'b1, 2'b10, 1'b1);
    checks++; if (pass2 !== 1'b1 || err2 !== 2'd0 || vec2 !== 2'd3) begin fails++; $display("FAIL sat_clean: got pass=%b err=%0d vec=%0d want 1 0 3", pass2, err2, vec2); end
  endtask

  task automatic test_abort();
    logic [1:0] ab;
    drv0(1'b1, 1'b0, 2'b00, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      ab = 2'((i - 1) % 4);
      drv0(1'b0, 1'b1, ab, ~(ab[1] & ab[0]));
    end
    checks++; if (vec0 !== 8'd10 || busy0 !== 1'b1) begin fails++; $display("FAIL abort_mid: got vec=%0d busy=%b want 10 1", vec0, busy0); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy0, done0, pass0, vec0, err0, fidx0, fab0} !== 29'd0) begin fails++; $display("FAIL abort_async: got %h want 0", {busy0, done0, pass0, vec0, err0, fidx0, fab0}); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    drv0(1'b1, 1'b0, 2'b00, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      ab = 2'((i - 1) % 4);
      drv0(1'b0, 1'b1, ab, ~(ab[1] & ab[0]));
    end
    checks++; if (vec0 !== 8'd20 || pass0 !== 1'b1 || err0 !== 8'd0) begin fails++; $display("FAIL abort_rerun: got vec=%0d pass=%b err=%0d want 20 1 0", vec0, pass0, err0); end
  endtask

  initial begin
    rst_n = 1'b0;
    {start0, vld0, a0, b0, x0} = '0;
    {start1, vld1, a1, b1, x1} = '0;
    {start2, vld2, a2, b2, x2} = '0;
    test_reset();
    test_clean_nand();
    test_fault();
    test_pipelined();
    test_saturation_restart();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
